// File: rtl/button_event_decoder_pkg.sv
// Shared button constants: decoder state encoding and default cycle counts
// derived from the 50 MHz board clock (also used by the debouncer stage).
package button_event_decoder_pkg;

  localparam int unsigned BOARD_CLK_HZ = 50_000_000;

  // 0.5 s long press, 0.25 s double-click gap, 10 ms debounce window
  localparam int unsigned DEF_LONG_CYCLES     = BOARD_CLK_HZ / 2;
  localparam int unsigned DEF_GAP_CYCLES      = BOARD_CLK_HZ / 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = BOARD_CLK_HZ / 100;
  localparam int unsigned DEF_TMR_W           = 25;
  localparam int unsigned DEF_CNT_W           = 8;

  // Decoder state encoding
  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_PRESS1 = 2'd1;
  localparam state_t ST_GAP    = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

endpackage : button_event_decoder_pkg

// File: rtl/button_event_decoder.sv
// Button gesture decoder: classifies debounced presses into click,
// double click and long press, emitting one-cycle registered pulses and a
// wrapping count of all emitted events.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   btn        debounced pressed level (1 = pressed), synchronous to clk
//   click      one-cycle pulse: short press with no second press in gap
//   dbl_click  one-cycle pulse: second press started within gap
//   long_press one-cycle pulse: press held LONG_CYCLES
//   evt_count  count of all emitted events, wraps silently
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned TMR_W       = DEF_TMR_W,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  output logic             click,
  output logic             dbl_click,
  output logic             long_press,
  output logic [CNT_W-1:0] evt_count
);

  localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             click_d, dbl_d, long_d;
  logic [CNT_W-1:0] evt_d;

  // Next-state, timer and event decode
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    click_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    evt_d   = evt_count;

    unique case (state_q)
      ST_HOLD: begin
        if (!btn) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      ST_IDLE: begin
        // This edge already counts as pressed cycle 1
        if (btn) begin
          state_d = ST_PRESS1;
          timer_d = TMR_ONE;
        end
      end
      ST_PRESS1: begin
        // Release checked first: it wins over the long-press timeout
        if (!btn) begin
          state_d = ST_GAP;
          timer_d = TMR_ONE;
        end else if (timer_q == LONG_LAST) begin
          state_d = ST_HOLD;
          timer_d = '0;
          long_d  = 1'b1;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_GAP: begin
        // Press checked first: it wins over the gap timeout
        if (btn) begin
          state_d = ST_HOLD;
          timer_d = '0;
          dbl_d   = 1'b1;
        end else if (timer_q == GAP_LAST) begin
          state_d = ST_IDLE;
          timer_d = '0;
          click_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      default: begin
        state_d = ST_HOLD;
        timer_d = '0;
      end
    endcase

    if (click_d || dbl_d || long_d) begin
      evt_d = evt_count + CNT_W'(1);
    end
  end

  // State, timer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      timer_q    <= '0;
      click      <= 1'b0;
      dbl_click  <= 1'b0;
      long_press <= 1'b0;
      evt_count  <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      click      <= click_d;
      dbl_click  <= dbl_d;
      long_press <= long_d;
      evt_count  <= evt_d;
    end
  end

endmodule : button_event_decoder

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=20,
// GAP_CYCLES=8, CNT_W=4.
module tb_button_event_decoder;

  localparam int unsigned LONG_CYCLES = 20;
  localparam int unsigned GAP_CYCLES  = 8;
  localparam int unsigned TMR_W       = 5;
  localparam int unsigned CNT_W       = 4;

  logic             clk;
  logic             rst;
  logic             btn;
  logic             click;
  logic             dbl_click;
  logic             long_press;
  logic [CNT_W-1:0] evt_count;

  int checks;
  int passed;

  // Per-cycle observation bookkeeping
  int cyc;
  int n_click, n_dbl, n_long, n_multi;
  int click_cyc, dbl_cyc, long_cyc;

  button_event_decoder #(
    .LONG_CYCLES(LONG_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .TMR_W      (TMR_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .click     (click),
    .dbl_click (dbl_click),
    .long_press(long_press),
    .evt_count (evt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_obs();
    n_click   = 0;
    n_dbl     = 0;
    n_long    = 0;
    click_cyc = -1;
    dbl_cyc   = -1;
    long_cyc  = -1;
  endtask

  // Drive btn for one edge, then sample the registered outputs 1 ns later
  task automatic step(input logic b);
    btn = b;
    @(posedge clk);
    #1;
    cyc++;
    if ((int'(click) + int'(dbl_click) + int'(long_press)) > 1) n_multi++;
    if (click === 1'b1) begin
      n_click++;
      if (click_cyc < 0) click_cyc = cyc;
    end
    if (dbl_click === 1'b1) begin
      n_dbl++;
      if (dbl_cyc < 0) dbl_cyc = cyc;
    end
    if (long_press === 1'b1) begin
      n_long++;
      if (long_cyc < 0) long_cyc = cyc;
    end
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  // Two reset edges, release, then one settling edge with btn=b (HOLD -> IDLE if b=0)
  task automatic do_reset(input logic b);
    rst = 1'b1;
    btn = b;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_obs();
    step(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({click, dbl_click, long_press} !== 3'b000)
      $display("FAIL reset_pulses: got %b expected 000", {click, dbl_click, long_press});
    else passed++;
    checks++;
    if (evt_count !== 4'd0)
      $display("FAIL reset_count: got %0d expected 0", evt_count);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_click();
    int base;
    do_reset(1'b0);
    run(1'b1, 5);
    base = cyc;
    run(1'b0, 10);
    checks++;
    if (click_cyc !== base + 8)
      $display("FAIL click_latency: got cycle %0d expected %0d", click_cyc, base + 8);
    else passed++;
    checks++;
    if (n_click !== 1 || n_dbl !== 0 || n_long !== 0)
      $display("FAIL click_pulses: got c=%0d d=%0d l=%0d expected 1/0/0", n_click, n_dbl, n_long);
    else passed++;
    checks++;
    if (evt_count !== 4'd1)
      $display("FAIL click_count: got %0d expected 1", evt_count);
    else passed++;
  endtask

  task automatic test_dbl_click();
    int base;
    do_reset(1'b0);
    run(1'b1, 3);
    run(1'b0, 4);
    base = cyc;
    run(1'b1, 3);
    run(1'b0, 12);
    checks++;
    if (dbl_cyc !== base + 1)
      $display("FAIL dbl_latency: got cycle %0d expected %0d", dbl_cyc, base + 1);
    else passed++;
    checks++;
    if (n_dbl !== 1 || n_click !== 0 || n_long !== 0)
      $display("FAIL dbl_pulses: got c=%0d d=%0d l=%0d expected 0/1/0", n_click, n_dbl, n_long);
    else passed++;
    checks++;
    if (evt_count !== 4'd1)
      $display("FAIL dbl_count: got %0d expected 1", evt_count);
    else passed++;
  endtask

  task automatic test_long_press();
    int base;
    do_reset(1'b0);
    base = cyc;
    run(1'b1, 30);
    run(1'b0, 12);
    checks++;
    if (long_cyc !== base + 20)
      $display("FAIL long_latency: got cycle %0d expected %0d", long_cyc, base + 20);
    else passed++;
    checks++;
    if (n_long !== 1 || n_click !== 0 || n_dbl !== 0)
      $display("FAIL long_pulses: got c=%0d d=%0d l=%0d expected 0/0/1", n_click, n_dbl, n_long);
    else passed++;
    checks++;
    if (evt_count !== 4'd1)
      $display("FAIL long_count: got %0d expected 1", evt_count);
    else passed++;
  endtask

  task automatic test_race_long();
    int base;
    do_reset(1'b0);
    run(1'b1, 19);
    base = cyc;
    run(1'b0, 10);
    checks++;
    if (n_long !== 0 || click_cyc !== base + 8)
      $display("FAIL race_long: got long=%0d click_cyc=%0d expected 0/%0d", n_long, click_cyc, base + 8);
    else passed++;
  endtask

  task automatic test_race_gap();
    int base;
    do_reset(1'b0);
    run(1'b1, 3);
    run(1'b0, 7);
    base = cyc;
    run(1'b1, 3);
    run(1'b0, 12);
    checks++;
    if (dbl_cyc !== base + 1 || n_click !== 0)
      $display("FAIL race_gap: got dbl_cyc=%0d clicks=%0d expected %0d/0", dbl_cyc, n_click, base + 1);
    else passed++;
  endtask

  task automatic test_hold_through_reset();
    int base;
    do_reset(1'b1);
    run(1'b1, 40);
    run(1'b0, 20);
    checks++;
    if ((n_click + n_dbl + n_long) !== 0 || evt_count !== 4'd0)
      $display("FAIL held_reset: got events=%0d count=%0d expected 0/0", n_click + n_dbl + n_long, evt_count);
    else passed++;
    run(1'b1, 3);
    base = cyc;
    run(1'b0, 10);
    checks++;
    if (click_cyc !== base + 8 || evt_count !== 4'd1)
      $display("FAIL held_then_click: got click_cyc=%0d count=%0d expected %0d/1", click_cyc, evt_count, base + 8);
    else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    run(1'b1, 10);
    do_reset(1'b0);
    run(1'b0, 30);
    checks++;
    if ((n_click + n_dbl + n_long) !== 0 || evt_count !== 4'd0)
      $display("FAIL mid_reset: got events=%0d count=%0d expected 0/0", n_click + n_dbl + n_long, evt_count);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] exp_cnt;
    do_reset(1'b0);
    for (int i = 1; i <= 18; i++) begin
      run(1'b1, 3);
      run(1'b0, 9);
      exp_cnt = CNT_W'(i % 16);
      if (i == 15 || i == 16 || i == 18) begin
        checks++;
        if (evt_count !== exp_cnt)
          $display("FAIL wrap_count_%0d: got %0d expected %0d", i, evt_count, exp_cnt);
        else passed++;
      end
    end
    checks++;
    if (n_click !== 18)
      $display("FAIL wrap_clicks: got %0d expected 18", n_click);
    else passed++;
  endtask

  task automatic test_one_hot();
    checks++;
    if (n_multi !== 0)
      $display("FAIL one_hot: got %0d multi-pulse cycles expected 0", n_multi);
    else passed++;
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    cyc     = 0;
    n_multi = 0;
    rst     = 1'b1;
    btn     = 1'b0;
    clear_obs();

    test_reset();
    test_click();
    test_dbl_click();
    test_long_press();
    test_race_long();
    test_race_gap();
    test_hold_through_reset();
    test_mid_reset();
    test_wrap();
    test_one_hot();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_button_event_decoder
